// File: rtl/exp_accel_stream_if.sv
// Stream handshake bundle for exp_accel_stream: sample input,
// exponential engine sequencing and result write channel.
interface exp_accel_stream_if #(
  parameter int V_W    = 5,
  parameter int U_W    = 2,
  parameter int X_W    = 16,
  parameter int INT_W  = 2,
  parameter int FRAC_W = 16,
  parameter int DEPTH  = 4
);
  localparam int OUT_W = INT_W + FRAC_W + (2**U_W) - 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              inValid;
  logic [V_W-1:0]    inV;
  logic [U_W-1:0]    inU;
  logic              inReady;

  logic              engStart;
  logic [X_W-1:0]    engX;
  logic              engDone;
  logic [INT_W-1:0]  engInt;
  logic [FRAC_W-1:0] engFrac;

  logic              wrReq;
  logic              wrAck;
  logic [OUT_W-1:0]  wrData;
  logic              wDone;

  logic              busy;
  logic [LW-1:0]     fifoLevel;

  modport master (
    output inValid, inV, inU,
    output engDone, engInt, engFrac,
    output wrAck,
    input  inReady, engStart, engX,
    input  wrReq, wrData, wDone,
    input  busy, fifoLevel
  );

  modport slave (
    input  inValid, inV, inU,
    input  engDone, engInt, engFrac,
    input  wrAck,
    output inReady, engStart, engX,
    output wrReq, wrData, wDone,
    output busy, fifoLevel
  );
endinterface

// File: rtl/exp_accel_stream.sv
// Streaming exponential sequencer: FIFO of (v,u) samples, one engine
// run per sample, result shifted by u and offered on a held write.
module exp_accel_stream #(
  parameter int V_W     = 5,
  parameter int U_W     = 2,
  parameter int X_W     = 16,
  parameter int X_SHIFT = 8,
  parameter int INT_W   = 2,
  parameter int FRAC_W  = 16,
  parameter int DEPTH   = 4
) (
  input logic clk,
  input logic rst,
  exp_accel_stream_if.slave bus
);
  localparam int OUT_W = INT_W + FRAC_W + (2**U_W) - 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic [V_W-1:0] memV [DEPTH];
  logic [U_W-1:0] memU [DEPTH];

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [X_W-1:0]   xReg;
  logic [U_W-1:0]   uReg;
  logic [OUT_W-1:0] dataReg;

  logic             engStart;
  logic             wrReq;
  logic             wDone;
  logic             busy;

  // Wrap bit in the pointers makes full/empty a plain subtraction
  assign level = wrPtr - rdPtr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign push  = bus.inValid && !full;
  assign pop   = (state == LOAD);

  always_ff @(posedge clk) begin
    if (push) begin
      memV[wrPtr[AW-1:0]] <= bus.inV;
      memU[wrPtr[AW-1:0]] <= bus.inU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (!empty) nextState = LOAD;
      LOAD:  nextState = START;
      START: nextState = WAIT;
      WAIT:  if (bus.engDone) nextState = WRITE;
      WRITE: begin
        if (bus.wrAck) nextState = empty ? DONE : LOAD;
      end
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    engStart = 1'b0;
    wrReq    = 1'b0;
    wDone    = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE:  busy     = 1'b0;
      START: engStart = 1'b1;
      WRITE: wrReq    = 1'b1;
      DONE:  wDone    = 1'b1;
      default: ;
    endcase
  end

  // Operand and shift are latched at pop so the FIFO slot can refill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xReg    <= '0;
      uReg    <= '0;
      dataReg <= '0;
    end else begin
      if (state == LOAD) begin
        xReg <= X_W'(memV[rdPtr[AW-1:0]]) << X_SHIFT;
        uReg <= memU[rdPtr[AW-1:0]];
      end
      if (state == WAIT && bus.engDone) begin
        dataReg <= OUT_W'({bus.engInt, bus.engFrac}) << uReg;
      end
    end
  end

  assign bus.inReady   = !full;
  assign bus.engStart  = engStart;
  assign bus.engX      = xReg;
  assign bus.wrReq     = wrReq;
  assign bus.wrData    = dataReg;
  assign bus.wDone     = wDone;
  assign bus.busy      = busy;
  assign bus.fifoLevel = level;
endmodule

// File: tb/tb_exp_accel_stream.sv
// Bench for exp_accel_stream: queue-based reference model checked
// every cycle, directed scenarios plus randomized traffic.
module tb_exp_accel_stream;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exp_accel_stream_if bus ();

  exp_accel_stream dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [4:0] v;
    logic [1:0] u;
  } samp_t;

  samp_t       pendQ[$];
  logic [20:0] resQ[$];
  bit          inflight = 0;
  logic [1:0]  inflU;
  logic [15:0] inflX;
  bit          expDone = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCnt = 0;
  int ackCnt = 0;
  int pushCnt = 0;
  int reqRun = 0;
  int lastReqRun = 0;
  int lastPushCyc = 0;
  int lastStartCyc = 0;
  int maxLevel = 0;
  logic [20:0] lastData = '0;
  logic [15:0] lastEngX = '0;

  int         engLat = 3;
  bit         engRand = 0;
  bit         engFixed = 0;
  logic [1:0] fixInt = '0;
  logic [15:0] fixFrac = '0;
  int         strayReq = 0;
  int         ackMode = 1;
  int         ackDelay = 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: sample queue, in-flight op, result queue
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      pendQ.delete();
      resQ.delete();
      inflight = 0;
      expDone = 0;
      reqRun = 0;
    end else begin
      chk("wrReq", 32'(bus.wrReq), 32'(resQ.size() != 0));
      chk("wDone", 32'(bus.wDone), 32'(expDone));
      chk("levelRange",
          32'(bus.fifoLevel == pendQ.size() ||
              bus.fifoLevel + 1 == pendQ.size()), 1);
      chk("inReady", 32'(bus.inReady),
          32'(bus.fifoLevel < DEPTH));
      if (bus.fifoLevel > maxLevel) maxLevel = bus.fifoLevel;
      expDone = 0;
      if (bus.wDone) doneCnt++;
      if (bus.wrReq) reqRun++;
      if (bus.wrReq && bus.wrAck) begin
        if (resQ.size() == 0) begin
          chk("wrNoResult", 1, 0);
        end else begin
          chk("wrData", 32'(bus.wrData), 32'(resQ[0]));
          void'(resQ.pop_front());
        end
        lastData = bus.wrData;
        lastReqRun = reqRun;
        reqRun = 0;
        ackCnt++;
        expDone = (pendQ.size() == 0);
      end
      if (bus.engStart) begin
        chk("startWhileBusy", 32'(inflight), 0);
        if (pendQ.size() == 0) begin
          chk("startNoSample", 1, 0);
        end else begin
          chk("engX", 32'(bus.engX), 32'(pendQ[0].v) * 256);
          inflU = pendQ[0].u;
          void'(pendQ.pop_front());
        end
        inflX = bus.engX;
        lastEngX = bus.engX;
        lastStartCyc = cyc;
        inflight = 1;
      end else if (inflight) begin
        chk("engXHold", 32'(bus.engX), 32'(inflX));
        if (bus.engDone) begin
          resQ.push_back(21'((bus.engInt * 32'h10000 +
                              bus.engFrac) *
                             (32'd1 << inflU)));
          inflight = 0;
        end
      end
      if (bus.inValid && bus.inReady) begin
        pendQ.push_back('{v: bus.inV, u: bus.inU});
        pushCnt++;
        lastPushCyc = cyc;
      end
    end
  end

  // Engine model: fixed or random latency and result
  initial begin
    int cnt;
    cnt = -1;
    bus.engDone = 0;
    bus.engInt = '0;
    bus.engFrac = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.engDone = 0;
      if (!rst) begin
        cnt = -1;
      end else if (bus.engStart) begin
        cnt = engRand ? int'($urandom_range(0, 5)) : engLat;
      end else if (cnt > 0) begin
        cnt--;
      end else if (cnt == 0) begin
        bus.engDone = 1;
        bus.engInt = engFixed ? fixInt : 2'($urandom);
        bus.engFrac = engFixed ? fixFrac : 16'($urandom);
        cnt = -1;
      end else if (strayReq != 0) begin
        bus.engDone = 1;
        bus.engInt = 2'($urandom);
        bus.engFrac = 16'($urandom);
        strayReq = 0;
      end
    end
  end

  // Result writer: random, delayed or permanently-high ack
  initial begin
    int reqCnt;
    reqCnt = 0;
    bus.wrAck = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wrReq) reqCnt++;
      else reqCnt = 0;
      case (ackMode)
        0: bus.wrAck = ($urandom_range(0, 2) == 0);
        1: bus.wrAck = bus.wrReq && (reqCnt >= ackDelay);
        default: bus.wrAck = 1;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] v,
                      input logic [1:0] u);
    int n;
    n = 0;
    bus.inValid = 1;
    bus.inV = v;
    bus.inU = u;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.inReady && n < 500);
    if (!bus.inReady) chk("pushTimeout", 0, 1);
    @(posedge clk);
    #1;
    bus.inValid = 0;
  endtask

  task automatic waitDone(input int d0);
    int n;
    n = 0;
    while (doneCnt == d0 && n < 3000) begin
      tick(1);
      n++;
    end
    chk("wDoneCount", 32'(doneCnt - d0), 1);
  endtask

  task automatic chkIdleOuts(input string tag);
    chk({tag, ".inReady"}, 32'(bus.inReady), 1);
    chk({tag, ".engStart"}, 32'(bus.engStart), 0);
    chk({tag, ".engX"}, 32'(bus.engX), 0);
    chk({tag, ".wrReq"}, 32'(bus.wrReq), 0);
    chk({tag, ".wrData"}, 32'(bus.wrData), 0);
    chk({tag, ".wDone"}, 32'(bus.wDone), 0);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".level"}, 32'(bus.fifoLevel), 0);
  endtask

  initial begin
    int d0;
    int a0;
    int p0;
    int n;
    int prevLvl;
    bit prevRdy;
    bus.inValid = 0;
    bus.inV = '0;
    bus.inU = '0;

    @(negedge clk);
    chkIdleOuts("reset");
    @(posedge clk);
    #1;
    rst = 1;
    tick(2);

    // Single sample, ack after 4 cycles of wrReq
    engLat = 3;
    engFixed = 1;
    fixInt = 2'd1;
    fixFrac = 16'h8000;
    ackMode = 1;
    ackDelay = 4;
    d0 = doneCnt;
    push(5'd5, 2'd2);
    waitDone(d0);
    chk("single.engX", 32'(lastEngX), 32'h0500);
    chk("single.data", 32'(lastData), 32'h60000);
    chk("single.reqCycles", 32'(lastReqRun), 4);
    chk("single.latency", 32'(lastStartCyc - lastPushCyc), 3);
    chk("single.idle", 32'(bus.busy), 0);

    // Shift bounds with maximal engine result
    ackDelay = 1;
    fixInt = 2'd3;
    fixFrac = 16'hFFFF;
    d0 = doneCnt;
    push(5'd31, 2'd0);
    waitDone(d0);
    chk("shift.u0", 32'(lastData), 32'h3FFFF);
    d0 = doneCnt;
    push(5'd0, 2'd3);
    waitDone(d0);
    chk("shift.u3", 32'(lastData), 32'h1FFFF8);

    // Burst of 6 back-to-back samples
    engFixed = 0;
    engLat = 10;
    maxLevel = 0;
    d0 = doneCnt;
    a0 = ackCnt;
    for (int i = 0; i < 6; i++) push(5'(i * 5 + 1), 2'(i));
    waitDone(d0);
    chk("burst.maxLevel", 32'(maxLevel), 4);
    chk("burst.acks", 32'(ackCnt - a0), 6);

    // Stray engDone while idle, wrAck held high throughout
    ackMode = 2;
    a0 = ackCnt;
    tick(2);
    strayReq = 1;
    tick(4);
    chk("stray.wrReq", 32'(bus.wrReq), 0);
    chk("stray.busy", 32'(bus.busy), 0);
    chk("stray.acks", 32'(ackCnt - a0), 0);
    engLat = 6;
    engFixed = 1;
    fixInt = 2'd2;
    fixFrac = 16'h1234;
    d0 = doneCnt;
    push(5'd7, 2'd1);
    waitDone(d0);
    chk("stray.data", 32'(lastData), 32'h42468);
    chk("stray.reqCycles", 32'(lastReqRun), 1);

    // Full FIFO while LOAD pops: refuse, then accept
    engFixed = 0;
    engLat = 30;
    ackMode = 1;
    ackDelay = 1;
    d0 = doneCnt;
    for (int i = 0; i < 5; i++) push(5'(i + 20), 2'(i));
    bus.inValid = 1;
    bus.inV = 5'd9;
    bus.inU = 2'd3;
    prevLvl = 0;
    prevRdy = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.inReady) begin
        prevLvl = bus.fifoLevel;
        prevRdy = 0;
      end
    end while (!bus.inReady && n < 500);
    chk("full.refuseLvl", 32'(prevLvl), 4);
    chk("full.refuseRdy", 32'(prevRdy), 0);
    chk("full.popLvl", 32'(bus.fifoLevel), 3);
    @(posedge clk);
    #1;
    bus.inValid = 0;
    @(negedge clk);
    chk("full.refillLvl", 32'(bus.fifoLevel), 4);
    tick(1);
    waitDone(d0);

    // Randomized traffic
    engRand = 1;
    ackMode = 0;
    p0 = pushCnt;
    a0 = ackCnt;
    for (int i = 0; i < 400; i++) begin
      bus.inValid = ($urandom_range(0, 2) == 0);
      bus.inV = 5'($urandom);
      bus.inU = 2'($urandom);
      tick(1);
    end
    bus.inValid = 0;
    n = 0;
    while ((bus.busy || bus.fifoLevel != 0) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("rand.drained", 32'(bus.busy), 0);
    chk("rand.count", 32'(ackCnt - a0), 32'(pushCnt - p0));

    // Reset mid-WAIT with 3 samples queued
    engRand = 0;
    engLat = 20;
    ackMode = 1;
    ackDelay = 1;
    tick(2);
    d0 = doneCnt;
    for (int i = 0; i < 4; i++) push(5'(i + 3), 2'(i));
    tick(3);
    chk("rst.preLevel", 32'(bus.fifoLevel), 3);
    chk("rst.preBusy", 32'(bus.busy), 1);
    #2;
    rst = 0;
    #1;
    chkIdleOuts("rstMid");
    tick(2);
    rst = 1;
    tick(40);
    chk("rst.noDone", 32'(doneCnt - d0), 0);
    chk("rst.level", 32'(bus.fifoLevel), 0);
    chk("rst.busy", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
